micro_udp_engine_tx_arb: RTL and testbench
==========================================

MICRO_UDP_ENGINE_TX_ARB -- requirements
Module: micro_udp_engine_tx_arb

Interface
REQ-001 SHALL have parameter ARP_PRIORITY, default 1'b1: 1 = ARP strictly wins ties, 0 = round-robin between ARP and UDP.
REQ-002 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports arp_tx_data/empty/startofpacket/endofpacket/valid  input  256/5/1/1/1  ARP frame stream (Avalon-ST, big-endian byte 0 in [255:248]).
REQ-005 SHALL have port arp_tx_ready  output  1  backpressure to ARP source.
REQ-006 SHALL have ports udp_tx_data/empty/startofpacket/endofpacket/valid  input  256/5/1/1/1  IPv4/UDP frame stream, same format.
REQ-007 SHALL have port udp_tx_ready  output  1  backpressure to UDP source.
REQ-008 SHALL have ports l4_tx_data/empty/startofpacket/endofpacket/valid  output  256/5/1/1/1  merged stream to Ethernet TX.
REQ-009 SHALL have port l4_tx_ready  input  1  backpressure from Ethernet TX.
REQ-010 SHALL have ports arp_pkt_cnt, udp_pkt_cnt  output  32 each  completed-packet counters.
REQ-011 SHALL have port err_no_sop  output  1  sticky: granted packet's first beat lacked startofpacket.

Function
REQ-012 SHALL implement FSM states S_IDLE, S_ARP, S_UDP; arbitration only in S_IDLE, never mid-packet.
REQ-013 In S_IDLE: all ready outputs 0, l4_tx_valid 0, l4_tx_data/empty/sop/eop 0.
REQ-014 In S_IDLE with only one source valid, SHALL move to that source's state next cycle (one-cycle arbitration bubble).
REQ-015 In S_IDLE with both valid: ARP_PRIORITY=1 -> S_ARP; ARP_PRIORITY=0 -> the source not recorded in last_grant register.
REQ-016 last_grant SHALL update on each S_IDLE exit; reset value = UDP (so ARP wins first tie in round-robin).
REQ-017 In S_ARP/S_UDP: l4_tx_* SHALL combinationally equal the granted source's data/empty/sop/eop/valid; granted ready = l4_tx_ready; other source ready = 0.
REQ-018 Beat accepted = granted valid && l4_tx_ready; accepted beat with eop SHALL return FSM to S_IDLE next cycle.
REQ-019 Single-beat packet (sop && eop same beat) SHALL be handled: one beat then S_IDLE.
REQ-020 Granted valid deasserted mid-packet SHALL hold grant (l4_tx_valid 0) until eop accepted; no timeout.
REQ-021 Counter of granted source SHALL increment by 1 on accepted eop beat, wrapping 2^32-1 -> 0.
REQ-022 First beat after grant lacking sop SHALL set err_no_sop; beat still forwarded; cleared only by reset.
REQ-023 Input valid changes in S_IDLE the same cycle as arbitration SHALL use that cycle's sampled values only.

Reset
REQ-024 reset SHALL force S_IDLE, last_grant=UDP, both counters 0, err_no_sop 0, all outputs to REQ-013 values the cycle after assertion.
REQ-025 Reset mid-packet SHALL abandon the packet without emitting eop; no downstream cleanup performed.

Structure
REQ-026 FSM state enum and arbiter source typedef (SRC_ARP, SRC_UDP) SHALL live in micro_udp_engine_pkg.
REQ-027 Packet counter SHALL be sub-module micro_udp_engine_pkt_cnt (enable, reset, 32-bit wrapping count), instantiated twice.
REQ-028 Block SHALL sit between ARP/UDP framers and micro_udp_engine_eth_tx input, with no added datapath registers.

Verification
REQ-029 ARP-only 2-beat packet, l4_tx_ready=1 -> S_IDLE bubble, 2 beats out identical, arp_pkt_cnt=1, udp_pkt_cnt=0.
REQ-030 Both valid, ARP_PRIORITY=0, 3 UDP + 3 ARP 1-beat packets queued -> output order ARP,UDP,ARP,UDP,ARP,UDP; counts 3/3.
REQ-031 Both valid, ARP_PRIORITY=1, 2 packets each -> ARP,ARP,UDP,UDP.
REQ-032 UDP 4-beat packet, l4_tx_ready toggled 1,0,1,0... and ARP valid mid-packet -> no ARP beat interleaved, udp_tx_ready tracks l4_tx_ready, arp_tx_ready stays 0.
REQ-033 UDP first beat sop=0 -> err_no_sop=1 and stays 1 after eop; reset -> 0.
REQ-034 reset asserted on beat 2 of 4 -> next cycle l4_tx_valid=0, counters 0; subsequent ARP packet forwarded normally.

Source files
------------

// File: rtl/micro_udp_engine_pkg.sv
// Shared types for the micro UDP engine: TX arbiter FSM states, source ids and widths.
package micro_udp_engine_pkg;

    localparam int DATA_W  = 256;
    localparam int EMPTY_W = 5;
    localparam int CNT_W   = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARP  = 2'd1,
        S_UDP  = 2'd2
    } state_e;

    typedef enum logic {
        SRC_ARP = 1'b0,
        SRC_UDP = 1'b1
    } src_e;

endpackage

// File: rtl/micro_udp_engine_pkt_cnt.sv
// Wrapping packet counter; one instance per arbiter source.
module micro_udp_engine_pkt_cnt
    import micro_udp_engine_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/micro_udp_engine_tx_arb.sv
// Packet-granular arbiter merging the ARP and IPv4/UDP frame streams onto the Ethernet TX input.
module micro_udp_engine_tx_arb
    import micro_udp_engine_pkg::*;
#(
    parameter logic ARP_PRIORITY = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  arp_tx_data,
    input  logic [EMPTY_W-1:0] arp_tx_empty,
    input  logic               arp_tx_startofpacket,
    input  logic               arp_tx_endofpacket,
    input  logic               arp_tx_valid,
    output logic               arp_tx_ready,
    input  logic [DATA_W-1:0]  udp_tx_data,
    input  logic [EMPTY_W-1:0] udp_tx_empty,
    input  logic               udp_tx_startofpacket,
    input  logic               udp_tx_endofpacket,
    input  logic               udp_tx_valid,
    output logic               udp_tx_ready,
    output logic [DATA_W-1:0]  l4_tx_data,
    output logic [EMPTY_W-1:0] l4_tx_empty,
    output logic               l4_tx_startofpacket,
    output logic               l4_tx_endofpacket,
    output logic               l4_tx_valid,
    input  logic               l4_tx_ready,
    output logic [CNT_W-1:0]   arp_pkt_cnt,
    output logic [CNT_W-1:0]   udp_pkt_cnt,
    output logic               err_no_sop
);

    state_e state_q, state_d;
    src_e   last_q, last_d;
    logic   first_q, first_d;
    logic   err_q, err_d;
    logic   acc, arp_done, udp_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            last_q  <= SRC_UDP;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        last_d              = last_q;
        first_d             = first_q;
        err_d               = err_q;
        arp_tx_ready        = 1'b0;
        udp_tx_ready        = 1'b0;
        l4_tx_data          = '0;
        l4_tx_empty         = '0;
        l4_tx_startofpacket = 1'b0;
        l4_tx_endofpacket   = 1'b0;
        l4_tx_valid         = 1'b0;
        acc                 = 1'b0;
        arp_done            = 1'b0;
        udp_done            = 1'b0;

        case (state_q)
            S_IDLE: begin
                // ARP takes a tie when it has priority or UDP had the last grant.
                if (arp_tx_valid && (!udp_tx_valid || ARP_PRIORITY || last_q == SRC_UDP)) begin
                    state_d = S_ARP;
                    last_d  = SRC_ARP;
                    first_d = 1'b1;
                end else if (udp_tx_valid) begin
                    state_d = S_UDP;
                    last_d  = SRC_UDP;
                    first_d = 1'b1;
                end
            end
            S_ARP: begin
                l4_tx_data          = arp_tx_data;
                l4_tx_empty         = arp_tx_empty;
                l4_tx_startofpacket = arp_tx_startofpacket;
                l4_tx_endofpacket   = arp_tx_endofpacket;
                l4_tx_valid         = arp_tx_valid;
                arp_tx_ready        = l4_tx_ready;
            end
            S_UDP: begin
                l4_tx_data          = udp_tx_data;
                l4_tx_empty         = udp_tx_empty;
                l4_tx_startofpacket = udp_tx_startofpacket;
                l4_tx_endofpacket   = udp_tx_endofpacket;
                l4_tx_valid         = udp_tx_valid;
                udp_tx_ready        = l4_tx_ready;
            end
            default: state_d = S_IDLE;
        endcase

        acc = (state_q != S_IDLE) && l4_tx_valid && l4_tx_ready;
        if (acc) begin
            first_d = 1'b0;
            // Malformed start is flagged but the beat still goes out.
            if (first_q && !l4_tx_startofpacket) begin
                err_d = 1'b1;
            end
            if (l4_tx_endofpacket) begin
                state_d  = S_IDLE;
                arp_done = (state_q == S_ARP);
                udp_done = (state_q == S_UDP);
            end
        end
    end

    assign err_no_sop = err_q;

    micro_udp_engine_pkt_cnt #(.W(CNT_W)) u_arp_cnt (
        .clk   (clk),
        .reset (reset),
        .en_i  (arp_done),
        .cnt_o (arp_pkt_cnt)
    );

    micro_udp_engine_pkt_cnt #(.W(CNT_W)) u_udp_cnt (
        .clk   (clk),
        .reset (reset),
        .en_i  (udp_done),
        .cnt_o (udp_pkt_cnt)
    );

endmodule

// File: tb/tb_micro_udp_engine_tx_arb.sv
// Directed bench: instance 0 uses strict ARP priority, instance 1 uses round-robin.
module tb_micro_udp_engine_tx_arb;

    logic         clk;
    logic         reset;
    logic [255:0] a_data [2];
    logic [4:0]   a_empty[2];
    logic         a_sop  [2];
    logic         a_eop  [2];
    logic         a_val  [2];
    logic         a_rdy  [2];
    logic [255:0] u_data [2];
    logic [4:0]   u_empty[2];
    logic         u_sop  [2];
    logic         u_eop  [2];
    logic         u_val  [2];
    logic         u_rdy  [2];
    logic [255:0] l_data [2];
    logic [4:0]   l_empty[2];
    logic         l_sop  [2];
    logic         l_eop  [2];
    logic         l_val  [2];
    logic         l_rdy  [2];
    logic [31:0]  a_cnt  [2];
    logic [31:0]  u_cnt  [2];
    logic         err    [2];

    int passed = 0;
    int failed = 0;
    int total  = 0;

    micro_udp_engine_tx_arb dut0 (
        .clk(clk), .reset(reset),
        .arp_tx_data(a_data[0]), .arp_tx_empty(a_empty[0]), .arp_tx_startofpacket(a_sop[0]),
        .arp_tx_endofpacket(a_eop[0]), .arp_tx_valid(a_val[0]), .arp_tx_ready(a_rdy[0]),
        .udp_tx_data(u_data[0]), .udp_tx_empty(u_empty[0]), .udp_tx_startofpacket(u_sop[0]),
        .udp_tx_endofpacket(u_eop[0]), .udp_tx_valid(u_val[0]), .udp_tx_ready(u_rdy[0]),
        .l4_tx_data(l_data[0]), .l4_tx_empty(l_empty[0]), .l4_tx_startofpacket(l_sop[0]),
        .l4_tx_endofpacket(l_eop[0]), .l4_tx_valid(l_val[0]), .l4_tx_ready(l_rdy[0]),
        .arp_pkt_cnt(a_cnt[0]), .udp_pkt_cnt(u_cnt[0]), .err_no_sop(err[0])
    );

    micro_udp_engine_tx_arb #(.ARP_PRIORITY(1'b0)) dut1 (
        .clk(clk), .reset(reset),
        .arp_tx_data(a_data[1]), .arp_tx_empty(a_empty[1]), .arp_tx_startofpacket(a_sop[1]),
        .arp_tx_endofpacket(a_eop[1]), .arp_tx_valid(a_val[1]), .arp_tx_ready(a_rdy[1]),
        .udp_tx_data(u_data[1]), .udp_tx_empty(u_empty[1]), .udp_tx_startofpacket(u_sop[1]),
        .udp_tx_endofpacket(u_eop[1]), .udp_tx_valid(u_val[1]), .udp_tx_ready(u_rdy[1]),
        .l4_tx_data(l_data[1]), .l4_tx_empty(l_empty[1]), .l4_tx_startofpacket(l_sop[1]),
        .l4_tx_endofpacket(l_eop[1]), .l4_tx_valid(l_val[1]), .l4_tx_ready(l_rdy[1]),
        .arp_pkt_cnt(a_cnt[1]), .udp_pkt_cnt(u_cnt[1]), .err_no_sop(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_arp(input int d, input logic v, input logic s, input logic e,
                           input logic [255:0] dat, input logic [4:0] emp);
        a_val[d] = v; a_sop[d] = s; a_eop[d] = e; a_data[d] = dat; a_empty[d] = emp;
    endtask

    task automatic set_udp(input int d, input logic v, input logic s, input logic e,
                           input logic [255:0] dat, input logic [4:0] emp);
        u_val[d] = v; u_sop[d] = s; u_eop[d] = e; u_data[d] = dat; u_empty[d] = emp;
    endtask

    task automatic clr(input int d);
        set_arp(d, 1'b0, 1'b0, 1'b0, '0, 5'd0);
        set_udp(d, 1'b0, 1'b0, 1'b0, '0, 5'd0);
    endtask

    // Both sources offer single-beat packets; exp_arp[k]=1 means beat k must come from ARP.
    task automatic run_mix(input int d, input int na, input int nu, input logic [7:0] exp_arp,
                           input string tag);
        int ra = na;
        int rn = nu;
        int k  = 0;
        for (int c = 0; c < 40 && k < na + nu; c++) begin
            step();
            set_arp(d, ra > 0, 1'b1, 1'b1, {8'hA0, 248'(ra)}, 5'd0);
            set_udp(d, rn > 0, 1'b1, 1'b1, {8'hB0, 248'(rn)}, 5'd0);
            l_rdy[d] = 1'b1;
            #2;
            if (l_val[d]) begin
                chk({tag, " src"}, 256'(l_data[d][255:248]), exp_arp[k] ? 256'h A0 : 256'h B0);
                k++;
            end
            if (a_val[d] && a_rdy[d]) ra--;
            if (u_val[d] && u_rdy[d]) rn--;
        end
        chk({tag, " beats"}, 256'(k), 256'(na + nu));
        step();
        clr(d);
    endtask

    initial begin
        int b;
        logic r;
        reset = 1'b1;
        clr(0); clr(1);
        l_rdy[0] = 1'b0; l_rdy[1] = 1'b0;
        step(); step();
        reset = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("rst l4_valid", 256'(l_val[d]), 256'd0);
            chk("rst l4_data", l_data[d], 256'd0);
            chk("rst readys", 256'({a_rdy[d], u_rdy[d]}), 256'd0);
            chk("rst counts", 256'({a_cnt[d], u_cnt[d]}), 256'd0);
            chk("rst err", 256'(err[d]), 256'd0);
        end

        // ARP-only two-beat packet
        step();
        set_arp(0, 1'b1, 1'b1, 1'b0, {8'hA1, 248'd10}, 5'd0);
        l_rdy[0] = 1'b1;
        #2;
        chk("A bubble valid", 256'(l_val[0]), 256'd0);
        chk("A bubble ready", 256'(a_rdy[0]), 256'd0);
        step();
        #2;
        chk("A b0 valid", 256'(l_val[0]), 256'd1);
        chk("A b0 data", l_data[0], {8'hA1, 248'd10});
        chk("A b0 sop", 256'(l_sop[0]), 256'd1);
        chk("A b0 ready", 256'(a_rdy[0]), 256'd1);
        step();
        set_arp(0, 1'b1, 1'b0, 1'b1, {8'hA1, 248'd11}, 5'd3);
        #2;
        chk("A b1 data", l_data[0], {8'hA1, 248'd11});
        chk("A b1 eop/empty", 256'({l_eop[0], l_empty[0]}), 256'({1'b1, 5'd3}));
        step();
        clr(0);
        #2;
        chk("A idle valid", 256'(l_val[0]), 256'd0);
        chk("A arp cnt", 256'(a_cnt[0]), 256'd1);
        chk("A udp cnt", 256'(u_cnt[0]), 256'd0);

        // Round-robin: ties alternate starting with ARP
        run_mix(1, 3, 3, 8'b0001_0101, "RR");
        #2;
        chk("RR arp cnt", 256'(a_cnt[1]), 256'd3);
        chk("RR udp cnt", 256'(u_cnt[1]), 256'd3);

        // Strict priority: ARP drains first
        run_mix(0, 2, 2, 8'b0000_0011, "PRI");
        #2;
        chk("PRI arp cnt", 256'(a_cnt[0]), 256'd3);
        chk("PRI udp cnt", 256'(u_cnt[0]), 256'd2);

        // UDP 4-beat under toggling backpressure with ARP pending
        step();
        set_udp(0, 1'b1, 1'b1, 1'b0, {8'hB1, 248'd0}, 5'd0);
        l_rdy[0] = 1'b1;
        #2;
        chk("D bubble valid", 256'(l_val[0]), 256'd0);
        b = 0;
        r = 1'b1;
        for (int c = 0; c < 20 && b < 4; c++) begin
            step();
            set_udp(0, 1'b1, b == 0, b == 3, {8'hB1, 248'(b)}, 5'd0);
            set_arp(0, c >= 1, 1'b1, 1'b1, {8'hA9, 248'd0}, 5'd0);
            l_rdy[0] = r;
            #2;
            chk("D udp ready", 256'(u_rdy[0]), 256'(r));
            chk("D arp ready", 256'(a_rdy[0]), 256'd0);
            chk("D data", l_data[0], {8'hB1, 248'(b)});
            if (r) b++;
            r = ~r;
        end
        chk("D beats", 256'(b), 256'd4);
        step();
        set_udp(0, 1'b0, 1'b0, 1'b0, '0, 5'd0);
        l_rdy[0] = 1'b1;
        #2;
        chk("D post idle", 256'(l_val[0]), 256'd0);
        chk("D udp cnt", 256'(u_cnt[0]), 256'd3);
        step();
        #2;
        chk("D arp after", l_data[0], {8'hA9, 248'd0});
        chk("D arp ready", 256'(a_rdy[0]), 256'd1);
        step();
        clr(0);
        #2;
        chk("D arp cnt", 256'(a_cnt[0]), 256'd4);

        // UDP first beat without sop
        step();
        set_udp(0, 1'b1, 1'b0, 1'b0, {8'hB2, 248'd0}, 5'd0);
        #2;
        step();
        #2;
        chk("E fwd valid", 256'(l_val[0]), 256'd1);
        chk("E fwd sop", 256'(l_sop[0]), 256'd0);
        step();
        set_udp(0, 1'b1, 1'b0, 1'b1, {8'hB2, 248'd1}, 5'd0);
        #2;
        chk("E err set", 256'(err[0]), 256'd1);
        step();
        clr(0);
        #2;
        chk("E err sticky", 256'(err[0]), 256'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #2;
        chk("E err cleared", 256'(err[0]), 256'd0);
        chk("E counts cleared", 256'({a_cnt[0], u_cnt[0]}), 256'd0);

        // Reset mid-packet
        step();
        set_arp(0, 1'b1, 1'b1, 1'b1, {8'hA5, 248'd0}, 5'd0);
        #2;
        step();
        #2;
        chk("F arp data", l_data[0], {8'hA5, 248'd0});
        step();
        clr(0);
        set_udp(0, 1'b1, 1'b1, 1'b0, {8'hB3, 248'd0}, 5'd0);
        #2;
        chk("F pre arp cnt", 256'(a_cnt[0]), 256'd1);
        step();
        #2;
        chk("F u b0", l_data[0], {8'hB3, 248'd0});
        step();
        set_udp(0, 1'b1, 1'b0, 1'b0, {8'hB3, 248'd1}, 5'd0);
        step();
        set_udp(0, 1'b1, 1'b0, 1'b0, {8'hB3, 248'd2}, 5'd0);
        reset = 1'b1;
        #2;
        chk("F u b2", l_data[0], {8'hB3, 248'd2});
        step();
        reset = 1'b0;
        clr(0);
        #2;
        chk("F rst valid", 256'(l_val[0]), 256'd0);
        chk("F rst counts", 256'({a_cnt[0], u_cnt[0]}), 256'd0);
        chk("F rst readys", 256'({a_rdy[0], u_rdy[0]}), 256'd0);
        step();
        set_arp(0, 1'b1, 1'b1, 1'b1, {8'hA6, 248'd0}, 5'd0);
        #2;
        chk("F new bubble", 256'(l_val[0]), 256'd0);
        step();
        #2;
        chk("F new data", l_data[0], {8'hA6, 248'd0});
        chk("F new eop", 256'({l_val[0], l_eop[0]}), 256'd3);
        step();
        clr(0);
        #2;
        chk("F new arp cnt", 256'(a_cnt[0]), 256'd1);
        chk("F new udp cnt", 256'(u_cnt[0]), 256'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
